display_scan_controller: RTL
============================

// Module: display_scan_controller
// PURPOSE
//  Upstream feeder for the anode decoder. Converts an 8-bit calculator result to BCD with a
//  sequential double-dabble engine. Time-multiplexes the digits by producing a 2-bit digit
//  select (drives the decoder's enable) and the matching active-low segment pattern.
//  Sits between the ALU result register and the 7-segment anode decoder.
// PARAMETERS
//  REFRESH_DIV  100000  clk cycles per digit slot (1 kHz per digit at 100 MHz); legal >= 2
// PORTS
//  clk          in   1   system clock, all state rising-edge
//  reset_n      in   1   synchronous reset, active low
//  value_in     in   8   result to display
//  value_valid  in   1   load strobe; sampled only when busy==0
//  busy         out  1   conversion in progress
//  digit_sel    out  2   digit slot to decoder: 0=ones 1=tens 2=hundreds 3=sign/unused
//  seg          out  7   cathodes, active low, {g,f,e,d,c,b,a}
//  bcd_out      out  12  committed display value {hundreds,tens,ones}, for visibility/test
// BEHAVIOUR
//  Reset (reset_n==0 at an edge):
//  - refresh counter=0, digit_sel=0, FSM=IDLE, busy=0, bcd_out=0, sign=0.
//  - seg therefore shows "0" (7'b1000000). Reset has priority over all other events.
//  - Reset mid-conversion aborts the conversion and discards it.
//  Scan:
//  - refresh_cnt counts 0..REFRESH_DIV-1 and then wraps.
//  - On the wrap edge, digit_sel increments mod 4 (3 -> 0).
//  - Scan runs continuously and is independent of conversion.
//  Conversion FSM (IDLE, SHIFT, DONE):
//  - IDLE: if value_valid, capture magnitude into shift reg, clear 12-bit scratch,
//    bit_cnt=0, go SHIFT, busy=1 from next cycle.
//  - SHIFT: each cycle add 3 to every scratch nibble >= 5, then shift {scratch,shreg} left 1.
//    bit_cnt++. After the 8th shift (bit_cnt==7), go DONE.
//  - DONE: commit scratch to bcd_out and sign to sign reg, go IDLE, busy=0 next cycle.
//  - Timing: valid sampled at edge E; busy high for cycles E+1..E+9.
//    bcd_out updates at edge E+9. busy low after E+9.
//  - value_valid while busy (including the DONE cycle) is ignored; no queueing.
//  - bcd_out holds its old value throughout a conversion, so the display never shows partial
//    results.
//  Segment select (combinational from digit_sel, bcd_out, sign):
//  - slot 0: ones, always shown.
//  - slot 1: tens; blank (7'h7F) if hundreds==0 and tens==0.
//  - slot 2: hundreds; blank if 0.
//  - slot 3: blank unless the optional feature is enabled and sign==1.
//  - Digit patterns 0-9: 40,79,24,30,19,12,02,78,00,10 (hex).
//  - Codes above 9 cannot occur; decode them as blank.
// CONFIGURATION
//  SIGNED_DISPLAY_EN defined:
//  - value_in is two's complement. Magnitude = |value_in|; -128 gives 128.
//  - sign = value_in[7]. Slot 3 shows '-' (7'b0111111) when sign==1, else blank.
//  SIGNED_DISPLAY_EN undefined:
//  - value_in is unsigned 0..255; sign is forced 0 and slot 3 is always blank.
// TESTING
//  (bench uses REFRESH_DIV=4)
//  1 reset_n=0 for 2 edges -> busy=0, digit_sel=0, bcd_out=12'h000, seg=7'h40.
//  2 value_in=255, valid 1 cycle -> busy high exactly 9 cycles; bcd_out=12'h255.
//    Slots 0/1/2 show 12,12,24; slot 3 shows 7F.
//  3 value_in=7 -> bcd_out=12'h007; slot0=78, slots 1/2/3=7F. value_in=105 -> slot1=40.
//  4 valid with 200, then valid with 50 three cycles later (busy) -> second ignored;
//    bcd_out=12'h200 and busy=0 after 9 cycles.
//  5 free-run 20 cycles -> digit_sel steps 0,1,2,3,0 every 4 cycles.
//    Assert reset_n=0 at cycle 4 of a conversion -> bcd_out=0, busy=0, digit_sel=0.
//  6 SIGNED_DISPLAY_EN: value_in=8'h80 -> bcd_out=12'h128, slot3=7'h3F.
//    value_in=8'hFF -> 12'h001, slot3=3F.
//    Undefined macro: 8'h80 -> 12'h128, slot3=7F.

Source files
------------

// File: rtl/display_scan_controller.sv
// display_scan_controller: double-dabble BCD conversion plus 4-slot 7-segment scan.
// Define SIGNED_DISPLAY_EN to treat value_in as two's complement and show '-' in slot 3.
module display_scan_controller #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  value_in,
  input  logic        value_valid,
  output logic        busy,
  output logic [1:0]  digit_sel,
  output logic [6:0]  seg,
  output logic [11:0] bcd_out
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [1:0] S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_sel, r_state;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh, w_mag;
  logic [11:0]   r_scr, r_bcd, w_adj;
  logic          r_sign, r_sign_cap, w_sign;
  logic [3:0]    w_dig;
  logic [6:0]    w_pat;
`ifdef SIGNED_DISPLAY_EN
  assign w_sign = value_in[7];
  assign w_mag  = value_in[7] ? ~value_in + 8'd1 : value_in;
`else
  assign w_sign = 1'b0;
  assign w_mag  = value_in;
`endif
  for (genvar i = 0; i < 3; i++) begin : g_adj
    assign w_adj[4*i+:4] = r_scr[4*i+:4] >= 4'd5 ? r_scr[4*i+:4] + 4'd3 : r_scr[4*i+:4];
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_sel <= '0;
    end else if (r_cnt == CW'(REFRESH_DIV - 1)) begin
      r_cnt <= '0;
      r_sel <= r_sel + 2'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
  // bcd_out and sign only change in DONE, so the display never sees partial results
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_bcd      <= '0;
      r_sign     <= 1'b0;
      r_sign_cap <= 1'b0;
      r_sh       <= '0;
      r_scr      <= '0;
      r_bit      <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (value_valid) begin
          r_sh       <= w_mag;
          r_scr      <= '0;
          r_bit      <= '0;
          r_sign_cap <= w_sign;
          r_state    <= S_SHIFT;
        end
        S_SHIFT: begin
          {r_scr, r_sh} <= {w_adj[10:0], r_sh, 1'b0};
          r_bit         <= r_bit + 3'd1;
          if (r_bit == 3'd7) r_state <= S_DONE;
        end
        S_DONE: begin
          r_bcd   <= r_scr;
          r_sign  <= r_sign_cap;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  always_comb begin
    w_dig = r_sel == 2'd0 ? r_bcd[3:0] : r_sel == 2'd1 ? r_bcd[7:4] : r_bcd[11:8];
    case (w_dig)
      4'd0: w_pat = 7'h40;
      4'd1: w_pat = 7'h79;
      4'd2: w_pat = 7'h24;
      4'd3: w_pat = 7'h30;
      4'd4: w_pat = 7'h19;
      4'd5: w_pat = 7'h12;
      4'd6: w_pat = 7'h02;
      4'd7: w_pat = 7'h78;
      4'd8: w_pat = 7'h00;
      4'd9: w_pat = 7'h10;
      default: w_pat = 7'h7F;
    endcase
  end
  assign seg = r_sel == 2'd3 ? (r_sign ? 7'h3F : 7'h7F) :
               ((r_sel == 2'd1 && r_bcd[11:4] == 8'd0) || (r_sel == 2'd2 && r_bcd[11:8] == 4'd0)) ? 7'h7F : w_pat;
  assign busy      = r_state != S_IDLE;
  assign digit_sel = r_sel;
  assign bcd_out   = r_bcd;
endmodule
